// File: rtl/charmap_pkg.sv
// charmap_pkg: shared op codes, FSM states and address helpers for the char-map blitter
package charmap_pkg;
    localparam int CHRAM_AW = 12;
    localparam int COORD_W = 6;
    typedef enum logic [1:0] {OP_NOP, OP_FILL, OP_SCROLL, OP_RSVD} op_e;
    typedef enum logic [2:0] {ST_IDLE, ST_FILL, ST_SCROLL_COPY, ST_SCROLL_BLANK, ST_DONE} state_e;
    function automatic logic [CHRAM_AW-1:0] cell_addr(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
        return {y, x};
    endfunction
endpackage

// File: rtl/charmap_cell_walker.sv
// charmap_cell_walker: x-fastest cell counter over a COLS x ROWS window with a fixed row offset
module charmap_cell_walker
    import charmap_pkg::*;
#(
    parameter int COLS = 40,
    parameter int ROWS = 30,
    parameter int YOFF = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               step,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               last
);
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic x_end, y_end;
    always_comb begin
        x_end = x_q == COORD_W'(COLS - 1);
        y_end = y_q == COORD_W'(ROWS - 1);
        x_d = start ? '0 : !step ? x_q : x_end ? '0 : x_q + COORD_W'(1);
        y_d = start ? '0 : !(step && x_end) ? y_q : y_end ? '0 : y_q + COORD_W'(1);
        last = x_end && y_end;
        x = x_q;
        y = y_q + COORD_W'(YOFF);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end
endmodule

// File: rtl/charmap_blitter.sv
// charmap_blitter: FILL / SCROLL_UP engine writing the char, fg and bg RAMs one cell per clock
module charmap_blitter
    import charmap_pkg::*;
#(
    parameter int COLS = 40,
    parameter int ROWS = 30
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [7:0]          cmd_char,
    input  logic [7:0]          cmd_fg,
    input  logic [7:0]          cmd_bg,
    output logic                busy,
    output logic                done,
    output logic [CHRAM_AW-1:0] chram_rd_addr,
    input  logic [7:0]          chmap_rd_data,
    input  logic [7:0]          fgcolram_rd_data,
    input  logic [7:0]          bgcolram_rd_data,
    output logic                chram_wr,
    output logic [CHRAM_AW-1:0] chram_wr_addr,
    output logic [7:0]          chmap_data_in,
    output logic [7:0]          fgcolram_data_in,
    output logic [7:0]          bgcolram_data_in
);
    state_e state_q, state_d;
    logic [7:0] char_q, char_d, fg_q, fg_d, bg_q, bg_d;
    logic pipe_q, pipe_d;
    logic accept, rd_step, rd_last, wr_last;
    logic [COORD_W-1:0] rx, ry, wx, wy;

    // Read walker runs one row below the write walker over the first ROWS-1 rows
    charmap_cell_walker #(.COLS(COLS), .ROWS(ROWS - 1), .YOFF(1)) u_rd_walk (
        .clk(clk), .reset(reset), .start(accept), .step(rd_step), .x(rx), .y(ry), .last(rd_last)
    );
    charmap_cell_walker #(.COLS(COLS), .ROWS(ROWS), .YOFF(0)) u_wr_walk (
        .clk(clk), .reset(reset), .start(accept), .step(chram_wr), .x(wx), .y(wy), .last(wr_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            char_q <= '0;
            fg_q <= '0;
            bg_q <= '0;
            pipe_q <= 1'b0;
        end else begin
            state_q <= state_d;
            char_q <= char_d;
            fg_q <= fg_d;
            bg_q <= bg_d;
            pipe_q <= pipe_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:         if (cmd_valid) state_d = cmd_op == OP_FILL ? ST_FILL : cmd_op == OP_SCROLL ? ST_SCROLL_COPY : ST_DONE;
            ST_FILL:         if (wr_last) state_d = ST_DONE;
            ST_SCROLL_COPY:  if (rd_last) state_d = ST_SCROLL_BLANK;
            ST_SCROLL_BLANK: if (wr_last) state_d = ST_DONE;
            default:         state_d = ST_IDLE;
        endcase
    end

    // A pending copy write (pipe_q) takes priority over blank-row fill in SCROLL_BLANK
    always_comb begin
        cmd_ready = state_q == ST_IDLE;
        accept = cmd_valid && cmd_ready;
        busy = state_q != ST_IDLE;
        done = state_q == ST_DONE;
        rd_step = state_q == ST_SCROLL_COPY;
        pipe_d = rd_step;
        char_d = accept ? cmd_char : char_q;
        fg_d = accept ? cmd_fg : fg_q;
        bg_d = accept ? cmd_bg : bg_q;
        chram_wr = state_q == ST_FILL || state_q == ST_SCROLL_BLANK || pipe_q;
        chram_rd_addr = rd_step ? cell_addr(rx, ry) : '0;
        chram_wr_addr = cell_addr(wx, wy);
        chmap_data_in = !chram_wr ? '0 : pipe_q ? chmap_rd_data : char_q;
        fgcolram_data_in = !chram_wr ? '0 : pipe_q ? fgcolram_rd_data : fg_q;
        bgcolram_data_in = !chram_wr ? '0 : pipe_q ? bgcolram_rd_data : bg_q;
    end
endmodule

// File: tb/tb_charmap_blitter.sv
// tb_charmap_blitter: directed checks of a 5x4 and a default 40x30 blitter against RAM models
module tb_charmap_blitter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [1:0] op = 2'd0;
    logic [7:0] ch = 8'h00, fg = 8'h00, bg = 8'h00;
    logic s_valid = 1'b0, d_valid = 1'b0;
    logic s_ready, s_busy, s_done, s_wr, d_ready, d_busy, d_done, d_wr;
    logic [11:0] s_rda, s_wra, d_rda, d_wra;
    logic [7:0] s_cr, s_fr, s_br, s_cw, s_fw, s_bw, d_cw, d_fw, d_bw;

    charmap_blitter #(.COLS(5), .ROWS(4)) u_s (
        .clk(clk), .reset(reset), .cmd_valid(s_valid), .cmd_ready(s_ready), .cmd_op(op),
        .cmd_char(ch), .cmd_fg(fg), .cmd_bg(bg), .busy(s_busy), .done(s_done),
        .chram_rd_addr(s_rda), .chmap_rd_data(s_cr), .fgcolram_rd_data(s_fr), .bgcolram_rd_data(s_br),
        .chram_wr(s_wr), .chram_wr_addr(s_wra), .chmap_data_in(s_cw), .fgcolram_data_in(s_fw),
        .bgcolram_data_in(s_bw)
    );
    charmap_blitter u_d (
        .clk(clk), .reset(reset), .cmd_valid(d_valid), .cmd_ready(d_ready), .cmd_op(op),
        .cmd_char(ch), .cmd_fg(fg), .cmd_bg(bg), .busy(d_busy), .done(d_done),
        .chram_rd_addr(d_rda), .chmap_rd_data(8'h00), .fgcolram_rd_data(8'h00), .bgcolram_rd_data(8'h00),
        .chram_wr(d_wr), .chram_wr_addr(d_wra), .chmap_data_in(d_cw), .fgcolram_data_in(d_fw),
        .bgcolram_data_in(d_bw)
    );

    logic [7:0] mc [4096];
    logic [7:0] mf [4096];
    logic [7:0] mb [4096];
    int cyc = 0, s_wn = 0, d_wn = 0, total = 0, bad = 0;
    logic lg_wr [4096];
    logic lg_ready [4096];
    logic lg_busy [4096];
    logic d_lg_wr [4096];
    logic [11:0] lg_wa [4096];
    logic [11:0] lg_ra [4096];
    logic [11:0] d_lg_wa [4096];

    always @(posedge clk) begin
        s_cr <= mc[s_rda];
        s_fr <= mf[s_rda];
        s_br <= mb[s_rda];
        if (s_wr) begin
            mc[s_wra] = s_cw;
            mf[s_wra] = s_fw;
            mb[s_wra] = s_bw;
            s_wn++;
        end
        if (d_wr) d_wn++;
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        lg_wr[cyc % 4096] = s_wr;
        lg_wa[cyc % 4096] = s_wra;
        lg_ra[cyc % 4096] = s_rda;
        lg_ready[cyc % 4096] = s_ready;
        lg_busy[cyc % 4096] = s_busy;
        d_lg_wr[cyc % 4096] = d_wr;
        d_lg_wa[cyc % 4096] = d_wra;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] ea(input int k, input int cols);
        return 12'(((k / cols) << 6) | (k % cols));
    endfunction

    // Presents one command for a single cycle, then scrambles the command fields
    task automatic cmd(input logic [1:0] o, input logic [7:0] c, input logic [7:0] f,
                       input logic [7:0] b, input bit dflt, output int t);
        @(negedge clk);
        op = o; ch = c; fg = f; bg = b;
        if (dflt) d_valid = 1'b1; else s_valid = 1'b1;
        t = cyc;
        @(negedge clk);
        s_valid = 1'b0; d_valid = 1'b0;
        op = 2'd1; ch = 8'hEE; fg = 8'hEE; bg = 8'hEE;
    endtask

    task automatic wait_done(input bit dflt, input int lim, output int dc);
        dc = -1;
        for (int i = 0; i < lim; i++) begin
            if (dflt ? d_done : s_done) begin
                dc = cyc;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic preload(input int mode);
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 5; x++) begin
                mc[y * 64 + x] = mode ? 8'(8'h30 + y) : 8'h00;
                mf[y * 64 + x] = mode ? 8'(8'h10 + y) : 8'h00;
                mb[y * 64 + x] = mode ? 8'(8'h50 + y) : 8'h00;
            end
    endtask

    int t, dc, w0;
    initial begin
        for (int i = 0; i < 4096; i++) begin
            mc[i] = 8'hAA; mf[i] = 8'hAA; mb[i] = 8'hAA;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wr_held", 32'(s_wr), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(s_ready), 1);
        chk("rst_busy", 32'(s_busy), 0);
        chk("rst_done", 32'(s_done), 0);
        chk("rst_wr", 32'(s_wr), 0);
        chk("rst_wra", 32'(s_wra), 0);
        chk("rst_rda", 32'(s_rda), 0);
        chk("rst_data", {8'h00, s_cw, s_fw, s_bw}, 0);
        chk("rst_d_ready", 32'(d_ready), 1);

        w0 = s_wn;
        cmd(2'd1, 8'h41, 8'h07, 8'h00, 1'b0, t);
        wait_done(1'b0, 100, dc);
        chk("fill_done_cyc", 32'(dc), 32'(t + 21));
        chk("fill_wcount", 32'(s_wn - w0), 20);
        chk("fill_wr_at_done", 32'(s_wr), 0);
        for (int k = 0; k < 20; k++) begin
            chk("fill_wr", 32'(lg_wr[(t + 1 + k) % 4096]), 1);
            chk("fill_wa", 32'(lg_wa[(t + 1 + k) % 4096]), 32'(ea(k, 5)));
        end
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 5; x++)
                chk("fill_cell", {8'h00, mc[y * 64 + x], mf[y * 64 + x], mb[y * 64 + x]}, 32'h00410700);
        chk("fill_out_x", 32'(mc[12'h005]), 32'hAA);
        chk("fill_out_y", 32'(mc[12'h100]), 32'hAA);
        @(negedge clk);
        chk("fill_idle_ready", 32'(s_ready), 1);

        preload(1);
        w0 = s_wn;
        cmd(2'd2, 8'h20, 8'h0F, 8'hFF, 1'b0, t);
        wait_done(1'b0, 100, dc);
        chk("scr_done_cyc", 32'(dc), 32'(t + 22));
        chk("scr_wcount", 32'(s_wn - w0), 20);
        chk("scr_no_wr_first", 32'(lg_wr[(t + 1) % 4096]), 0);
        for (int k = 0; k < 15; k++)
            chk("scr_ra", 32'(lg_ra[(t + 1 + k) % 4096]), 32'(ea(k, 5) + 12'h040));
        for (int k = 0; k < 20; k++) begin
            chk("scr_wr", 32'(lg_wr[(t + 2 + k) % 4096]), 1);
            chk("scr_wa", 32'(lg_wa[(t + 2 + k) % 4096]), 32'(ea(k, 5)));
        end
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 5; x++)
                chk("scr_cell", {8'h00, mc[y * 64 + x], mf[y * 64 + x], mb[y * 64 + x]},
                    y == 3 ? 32'h00200FFF : {8'h00, 8'(8'h31 + y), 8'(8'h11 + y), 8'(8'h51 + y)});
        chk("scr_out_x", 32'(mc[12'h005]), 32'hAA);

        @(negedge clk);
        op = 2'd1; ch = 8'h44; fg = 8'h01; bg = 8'h02; s_valid = 1'b1;
        t = cyc;
        w0 = s_wn;
        @(negedge clk);
        op = 2'd2; ch = 8'h20;
        wait_done(1'b0, 100, dc);
        chk("busy_done_cyc", 32'(dc), 32'(t + 21));
        chk("busy_wcount", 32'(s_wn - w0), 20);
        chk("busy_ready_mid", 32'(lg_ready[(t + 5) % 4096]), 0);
        chk("busy_busy_mid", 32'(lg_busy[(t + 5) % 4096]), 1);
        chk("busy_ready_done", 32'(s_ready), 0);
        @(negedge clk);
        chk("busy_ready_after", 32'(s_ready), 1);
        t = cyc;
        @(negedge clk);
        s_valid = 1'b0;
        chk("busy_second_acc", 32'(s_busy), 1);
        wait_done(1'b0, 100, dc);
        chk("busy_second_done", 32'(dc), 32'(t + 22));

        @(negedge clk);
        preload(0);
        cmd(2'd1, 8'h55, 8'h05, 8'h06, 1'b0, t);
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_wr_next", 32'(lg_wr[(t + 9) % 4096]), 0);
        chk("abort_wr_now", 32'(s_wr), 0);
        chk("abort_ready", 32'(s_ready), 1);
        chk("abort_cell7", 32'(mc[12'h042]), 32'h55);
        chk("abort_cell8", 32'(mc[12'h043]), 32'h00);
        chk("abort_cell19", 32'(mc[12'h0C4]), 32'h00);
        cmd(2'd1, 8'h66, 8'h16, 8'h26, 1'b0, t);
        wait_done(1'b0, 100, dc);
        chk("abort_refill_done", 32'(dc), 32'(t + 21));
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 5; x++)
                chk("abort_refill_cell", {8'h00, mc[y * 64 + x], mf[y * 64 + x], mb[y * 64 + x]}, 32'h00661626);

        @(negedge clk);
        w0 = s_wn;
        cmd(2'd3, 8'h77, 8'h77, 8'h77, 1'b0, t);
        wait_done(1'b0, 20, dc);
        chk("rsvd_done_cyc", 32'(dc), 32'(t + 1));
        repeat (2) @(negedge clk);
        chk("rsvd_wcount", 32'(s_wn - w0), 0);
        chk("rsvd_ready", 32'(s_ready), 1);

        w0 = d_wn;
        cmd(2'd1, 8'h12, 8'h34, 8'h56, 1'b1, t);
        wait_done(1'b1, 1400, dc);
        chk("dflt_done_cyc", 32'(dc), 32'(t + 1201));
        chk("dflt_wcount", 32'(d_wn - w0), 1200);
        chk("dflt_first_wa", 32'(d_lg_wa[(t + 1) % 4096]), 0);
        chk("dflt_row1_wa", 32'(d_lg_wa[(t + 41) % 4096]), 32'h040);
        chk("dflt_last_wr", 32'(d_lg_wr[(t + 1200) % 4096]), 1);
        chk("dflt_last_wa", 32'(d_lg_wa[(t + 1200) % 4096]), 32'h767);
        chk("dflt_no_wr_at_done", 32'(d_wr), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
